pwm_multi: RTL and testbench
============================

# pwm_multi

Multi-channel, parametrised PWM generator and successor to the single-channel `PWM` block. All `CH` channels share one counter and have independent duty references. Period and duty values are double-buffered and committed only at a period boundary, so updates never produce runt pulses. An optional center-aligned mode is available. The block sits between the control logic that writes duty references and the power-stage or LED pins.

## Interface
Parameters:
- `CH`, 4: number of PWM channels.
- `CW`, 13: counter, period and duty width (5000 counts at 50 MHz / 10 kHz).
- `DEFAULT_PERIOD`, 5000: active period after reset.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  counter run enable.
- `period`  in  CW  requested period, in clocks per PWM cycle.
- `duty`  in  CH*CW  packed duty references; channel i uses `[i*CW +: CW]`.
- `center`  in  1  requested alignment mode; 1 = center-aligned (see Configuration).
- `load`  in  1  staging strobe for `period`, `duty` and `center`.
- `load_ack`  out  1  one-cycle pulse when staged values become active.
- `pwm`  out  CH  PWM outputs.
- `cnt`  out  CW  current counter value.
- `period_start`  out  1  one-cycle pulse at the start of every PWM cycle.

## Operation
- Reset (asynchronous, any time, including mid-period):
  - Counter: `cnt`=0, direction=up.
  - Active registers: period=`DEFAULT_PERIOD`, all duties=0, mode=edge.
  - Staging: pending=0.
  - Outputs: `pwm`=0, `load_ack`=0, `period_start`=0.
- Staging:
  - `load`=1 captures `period`, `duty` and `center` into staging registers and sets pending.
  - A further `load` while pending overwrites staging; last write wins. Only one `load_ack` is issued.
- Commit (active <= staging, clear pending, pulse `load_ack`):
  - With `en`=1: on the clock where the counter wraps to the start of a new cycle.
  - With `en`=0: on the clock after the capture.
  - `load` on the same clock as a wrap: the new values are staged and commit at the following wrap, not the current one.
- Edge-aligned counter (mode=edge): with `en`=1, counts 0,1,…,P-1,0,…; the wrap is P-1 -> 0.
- Period boundaries:
  - P=0: counter is held at 0 and all `pwm` outputs are 0.
  - P=1: counter is held at 0; a commit occurs every clock.
- Compare (edge mode): `pwm[i]` = registered (`cnt` < D_i).
  - D_i=0: constant 0.
  - D_i>=P: constant 1, i.e. 100%.
- Enable behaviour: `en`=0 freezes `cnt` and the direction; `pwm` keeps comparing the frozen `cnt`, so levels hold.
- Widths: all compares are unsigned, CW bits. No arithmetic overflow is possible because the counter never exceeds P-1.

## Timing
- `pwm` and `period_start` are registered and reflect the `cnt` value from the previous clock: 1-cycle latency from counter to pin.
- Edge mode: `pwm[i]` is high for exactly D_i consecutive clocks of every P.
- `period_start` is high for one clock, aligned with `pwm` rising for any non-zero duty.
- `load_ack` is high on the clock after commit.
- The first PWM cycle using new values begins on the clock `load_ack` is high.

## Configuration
Macro: `PWM_CENTER_ALIGN_EN`.

- Defined: `center`=1, once committed, selects up/down counting.
  - Sequence: 0,1,…,P-1,P-1,P-2,…,0,0,…; both endpoints are held for one extra clock, giving a cycle length of 2P.
  - `pwm[i]` = registered (`cnt` < D_i), so the output is high for 2·D_i clocks, symmetric about the bottom turnaround.
  - The wrap, commit point and `period_start` are at the down->up turnaround at 0.
- Not defined: the `center` port remains for interface stability but is ignored; the block is edge-aligned only, and the up/down logic is not synthesised.

## Test plan
- Reset: after 10,000 clocks of running, pull `rst_n` low between clock edges -> `pwm`, `cnt`, `load_ack` and `period_start` go to 0 immediately. After release, P=5000 and all duties=0.
- Basic duty: load P=5000, duty ch0=100 and ch1=2500 with `en`=1 -> `pwm[0]` high 100 of every 5000 clocks, `pwm[1]` high 2500 of every 5000. `period_start` pulses every 5000 clocks.
- Glitch-free update: with ch0=100 running, load ch0=500 at `cnt`=2000 -> current cycle keeps its 100-clock pulse. `load_ack` pulses once at the wrap; the next cycle has a 500-clock pulse. A second `load` of ch0=1000 at `cnt`=3000 in the same cycle -> only 1000 is committed, with a single `load_ack`.
- Boundary duties: ch2=0 -> `pwm[2]` constantly 0; ch3=5000 and ch0=6000 -> both constantly 1. Load P=0 -> all outputs 0 and `cnt` held at 0.
- Enable freeze: drop `en` at `cnt`=1234 -> `cnt` holds 1234 and `pwm` levels hold. A `load` while `en`=0 -> `load_ack` on the next clock. Raise `en` -> counting resumes from 1235.
- Center mode (`PWM_CENTER_ALIGN_EN` defined): load P=100, D=30, `center`=1 -> 200-clock cycle, `pwm` high 60 clocks centered on `cnt`=0. Without the macro, the same stimulus gives a 100-clock cycle with 30 clocks high.

Source files
------------

// File: rtl/pwm_multi.sv
// pwm_multi: CH-channel PWM generator sharing one counter.
// Period, duties and alignment mode are staged by 'load' and committed only at
// a period boundary (or on the clock after capture while the counter is
// stopped), so an update never truncates or stretches a pulse.
// Optional feature macro: PWM_CENTER_ALIGN_EN selects up/down counting when the
// committed 'center' bit is set; without it the block is edge-aligned only.
module pwm_multi #(
  parameter int CH             = 4,
  parameter int CW             = 13,
  parameter int DEFAULT_PERIOD = 5000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CW-1:0]    period,
  input  logic [CH*CW-1:0] duty,
  input  logic             center,
  input  logic             load,
  output logic             load_ack,
  output logic [CH-1:0]    pwm,
  output logic [CW-1:0]    cnt,
  output logic             period_start
);

  typedef logic [CH-1:0][CW-1:0] duty_t;

  logic [CW-1:0] act_period;
  logic [CW-1:0] stg_period;
  duty_t         act_duty;
  duty_t         stg_duty;
  logic          pending;
  logic          short_period;
  logic          wrap;
  logic          commit;
  logic          at_start;
  logic [CW-1:0] cnt_next;
  logic [CH-1:0] pwm_next;

`ifdef PWM_CENTER_ALIGN_EN
  logic act_center;
  logic stg_center;
  logic dir_down;
  logic dir_down_next;
`else
  // The port is kept for interface compatibility; edge-only builds ignore it.
  logic unused_center;
  assign unused_center = center;
`endif

  // P=0 and P=1 both hold the counter at 0 and treat every clock as a boundary.
  assign short_period = (act_period <= CW'(1));
  assign commit       = pending & (wrap | ~en);

`ifdef PWM_CENTER_ALIGN_EN
  assign at_start = en & (act_period != '0) & (cnt == '0) & ~dir_down;
`else
  assign at_start = en & (act_period != '0) & (cnt == '0);
`endif

  // Next counter value and boundary detection for the active mode.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    cnt_next = cnt;
    wrap     = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
    dir_down_next = dir_down;
`endif
    if (en) begin
      if (short_period) begin
        cnt_next = '0;
        wrap     = 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
        dir_down_next = 1'b0;
      end else if (act_center) begin
        // Up/down: both endpoints are held one extra clock; the boundary is the bottom turnaround.
        if (!dir_down) begin
          if (cnt >= act_period - CW'(1)) dir_down_next = 1'b1;
          else                            cnt_next      = cnt + CW'(1);
        end else if (cnt == '0) begin
          dir_down_next = 1'b0;
          wrap          = 1'b1;
        end else begin
          cnt_next = cnt - CW'(1);
        end
`endif
      end else begin
`ifdef PWM_CENTER_ALIGN_EN
        dir_down_next = 1'b0;
`endif
        // '>=' rather than '==' recovers cleanly if a shorter period was committed while stopped.
        if (cnt >= act_period - CW'(1)) begin
          cnt_next = '0;
          wrap     = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
    end
  end

  // Counter (and direction) register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_down <= 1'b0;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
      cnt <= cnt_next;
`ifdef PWM_CENTER_ALIGN_EN
      dir_down <= dir_down_next;
`endif
    end
  end

  // Staging registers: last load wins until the next commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: staging is reset as well, so a commit can never copy X into the active set.
      stg_period <= CW'(DEFAULT_PERIOD);
      stg_duty   <= '0;
      pending    <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      stg_center <= 1'b0;
`endif
    end else begin
      if (load) begin
        stg_period <= period;
        stg_duty   <= duty;
`ifdef PWM_CENTER_ALIGN_EN
        stg_center <= center;
`endif
      end
      // A load on the commit clock re-arms pending for the following boundary.
      if (load)        pending <= 1'b1;
      else if (commit) pending <= 1'b0;
    end
  end

  // Active registers: only change at a boundary (or while stopped).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_period <= CW'(DEFAULT_PERIOD);
      act_duty   <= '0;
`ifdef PWM_CENTER_ALIGN_EN
      act_center <= 1'b0;
`endif
    end else if (commit) begin
      act_period <= stg_period;
      act_duty   <= stg_duty;
`ifdef PWM_CENTER_ALIGN_EN
      act_center <= stg_center;
`endif
    end
  end

  // Per-channel compare of the current count; a zero period forces all outputs low.
  always_comb begin
    pwm_next = '0;
    for (int i = 0; i < CH; i++) begin
      pwm_next[i] = (act_period != '0) && (cnt < act_duty[i]);
    end
  end

  // Registered outputs: one clock of latency from counter to pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm          <= '0;
      period_start <= 1'b0;
      load_ack     <= 1'b0;
    end else begin
      pwm          <= pwm_next;
      period_start <= at_start;
      load_ack     <= commit;
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: self-checking bench for pwm_multi.
// A cycle-position model predicts every output each clock; directed scenarios
// add hand-computed pulse-width, period and latency expectations.
module tb_pwm_multi;

  localparam int CH             = 4;
  localparam int CW             = 13;
  localparam int DEFAULT_PERIOD = 5000;
`ifdef PWM_CENTER_ALIGN_EN
  localparam bit CENTER_BUILD = 1'b1;
`else
  localparam bit CENTER_BUILD = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [CW-1:0]    period;
  logic [CH*CW-1:0] duty;
  logic             center;
  logic             load;
  logic             load_ack;
  logic [CH-1:0]    pwm;
  logic [CW-1:0]    cnt;
  logic             period_start;

  int checks = 0;
  int errors = 0;

  pwm_multi #(.CH(CH), .CW(CW), .DEFAULT_PERIOD(DEFAULT_PERIOD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .period(period), .duty(duty),
    .center(center), .load(load), .load_ack(load_ack), .pwm(pwm),
    .cnt(cnt), .period_start(period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The cycle is tracked as a position k in [0, cycle length); the count shown
  // for a position follows from the alignment rule, not from a step-by-step counter.
  int            m_p, m_k, s_p;
  int            m_duty [CH];
  int            s_duty [CH];
  bit            m_center, s_center, m_pend;
  logic [CH-1:0] exp_pwm;
  logic          exp_ps, exp_ack;
  logic [CW-1:0] exp_cnt;

  function automatic int pos_to_cnt(input int k, input int p, input bit ctr);
    return (ctr && k >= p) ? (2 * p - 1 - k) : k;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int c;
    int len;
    bit wrap_now;
    bit commit;
    if (!rst_n) begin
      m_p = DEFAULT_PERIOD; m_k = 0; m_center = 0; m_pend = 0;
      s_p = DEFAULT_PERIOD; s_center = 0;
      for (int i = 0; i < CH; i++) begin m_duty[i] = 0; s_duty[i] = 0; end
      exp_pwm = '0; exp_ps = 1'b0; exp_ack = 1'b0; exp_cnt = '0;
    end else begin
      c = pos_to_cnt(m_k, m_p, m_center);
      for (int i = 0; i < CH; i++) exp_pwm[i] = (m_p != 0) && (c < m_duty[i]);
      exp_ps   = en && (m_p != 0) && (m_k == 0);
      len      = m_center ? 2 * m_p : m_p;
      wrap_now = en && (m_p <= 1 || m_k == len - 1);
      commit   = m_pend && (!en || wrap_now);
      if (en) m_k = wrap_now ? 0 : m_k + 1;
      if (commit) begin
        m_p = s_p; m_center = s_center;
        for (int i = 0; i < CH; i++) m_duty[i] = s_duty[i];
      end
      exp_ack = commit;
      if (load) begin
        m_pend   = 1;
        s_p      = int'(period);
        s_center = CENTER_BUILD && center;
        for (int i = 0; i < CH; i++) s_duty[i] = int'(duty[i*CW +: CW]);
      end else if (commit) begin
        m_pend = 0;
      end
      exp_cnt = CW'(pos_to_cnt(m_k, m_p, m_center));
    end
  end

  // Compare process: every clock out of reset, 3 time units after the edge.
  always @(posedge clk) begin
    #3;
    if (rst_n) begin
      check("pwm", 64'(pwm), 64'(exp_pwm));
      check("cnt", 64'(cnt), 64'(exp_cnt));
      check("period_start", 64'(period_start), 64'(exp_ps));
      check("load_ack", 64'(load_ack), 64'(exp_ack));
    end
  end

  // ---------------- stimulus helpers ----------------
  int hi_cnt [CH];
  int ps_cnt, ack_cnt;

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic do_load(input int p, input int d0, input int d1, input int d2,
                         input int d3, input bit c);
    period = CW'(p);
    duty   = {CW'(d3), CW'(d2), CW'(d1), CW'(d0)};
    center = c;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  task automatic wait_cnt(input int v);
    for (int i = 0; i < 12000 && cnt !== CW'(v); i++) tick();
    check("wait_cnt", 64'(cnt), 64'(v));
  endtask

  task automatic wait_ps();
    for (int i = 0; i < 12000 && period_start !== 1'b1; i++) tick();
    check("wait_period_start", 64'(period_start), 64'd1);
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 12000 && load_ack !== 1'b1; i++) tick();
    check("wait_load_ack", 64'(load_ack), 64'd1);
  endtask

  task automatic measure(input int n);
    for (int ch = 0; ch < CH; ch++) hi_cnt[ch] = 0;
    ps_cnt = 0; ack_cnt = 0;
    for (int t = 0; t < n; t++) begin
      for (int ch = 0; ch < CH; ch++) hi_cnt[ch] += int'(pwm[ch]);
      ps_cnt  += int'(period_start);
      ack_cnt += int'(load_ack);
      tick();
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; period = '0; duty = '0; center = 1'b0;
    repeat (3) tick();
    #4 rst_n = 1'b1;
    tick();

    // Reset mid-period after a long run.
    en = 1'b1;
    do_load(5000, 3000, 0, 0, 0, 1'b0);
    repeat (10000) tick();
    wait_cnt(1000);
    check("pwm0_before_reset", 64'(pwm[0]), 64'd1);
    #4 rst_n = 1'b0;
    #1;
    check("rst_pwm", 64'(pwm), 64'd0);
    check("rst_cnt", 64'(cnt), 64'd0);
    check("rst_load_ack", 64'(load_ack), 64'd0);
    check("rst_period_start", 64'(period_start), 64'd0);
    tick();
    #4 rst_n = 1'b1;
    tick();
    wait_ps();
    measure(5000);
    check("post_rst_pwm_high", 64'(hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3]), 64'd0);
    check("post_rst_ps_per_5000", 64'(ps_cnt), 64'd1);
    wait_cnt(4999);
    tick();
    check("post_rst_wrap_to_0", 64'(cnt), 64'd0);

    // Basic duties plus the 0 and P boundaries.
    do_load(5000, 100, 2500, 0, 5000, 1'b0);
    wait_ack();
    wait_ps();
    measure(5000);
    check("basic_ch0_high", 64'(hi_cnt[0]), 64'd100);
    check("basic_ch1_high", 64'(hi_cnt[1]), 64'd2500);
    check("basic_ch2_zero", 64'(hi_cnt[2]), 64'd0);
    check("basic_ch3_full", 64'(hi_cnt[3]), 64'd5000);
    check("basic_ps_count", 64'(ps_cnt), 64'd1);

    // Glitch-free update: two loads in one cycle, the last one wins with a single ack.
    wait_ps();
    for (int ch = 0; ch < CH; ch++) hi_cnt[ch] = 0;
    ack_cnt = 0;
    for (int t = 0; t < 5000; t++) begin
      hi_cnt[0] += int'(pwm[0]);
      ack_cnt   += int'(load_ack);
      if (t == 1999) duty[0 +: CW] = CW'(500);
      if (t == 2999) duty[0 +: CW] = CW'(1000);
      load = (t == 1999) || (t == 2999);
      tick();
    end
    load = 1'b0;
    check("glitch_cur_cycle_ch0", 64'(hi_cnt[0]), 64'd100);
    check("glitch_single_ack", 64'(ack_cnt), 64'd1);
    measure(5000);
    check("glitch_next_cycle_ch0", 64'(hi_cnt[0]), 64'd1000);
    check("glitch_next_cycle_ch1", 64'(hi_cnt[1]), 64'd2500);
    check("glitch_no_extra_ack", 64'(ack_cnt), 64'd0);

    // Duty above the period is 100%; a zero period silences everything.
    do_load(5000, 6000, 2500, 0, 5000, 1'b0);
    wait_ack();
    wait_ps();
    measure(5000);
    check("over_ch0_full", 64'(hi_cnt[0]), 64'd5000);
    check("over_ch3_full", 64'(hi_cnt[3]), 64'd5000);
    do_load(0, 6000, 2500, 0, 5000, 1'b0);
    wait_ack();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("p0_pwm", 64'(pwm), 64'd0);
      check("p0_cnt", 64'(cnt), 64'd0);
      tick();
    end

    // Enable freeze, load while stopped, resume.
    do_load(5000, 2000, 0, 0, 0, 1'b0);
    wait_ack();
    wait_cnt(1234);
    en = 1'b0;
    tick();
    check("freeze_cnt", 64'(cnt), 64'd1234);
    check("freeze_pwm", 64'(pwm), 64'd1);
    repeat (10) tick();
    check("freeze_cnt_held", 64'(cnt), 64'd1234);
    check("freeze_pwm_held", 64'(pwm), 64'd1);
    do_load(5000, 3000, 0, 0, 0, 1'b0);
    check("stopped_ack_not_yet", 64'(load_ack), 64'd0);
    tick();
    check("stopped_ack_next_clk", 64'(load_ack), 64'd1);
    check("stopped_cnt_still", 64'(cnt), 64'd1234);
    en = 1'b1;
    tick();
    check("resume_cnt", 64'(cnt), 64'd1235);

    // Center request: 200-clock cycle with 60 high when built in, else 100 with 30.
    do_load(100, 30, 0, 0, 0, 1'b1);
    wait_ack();
    wait_ps();
    measure(CENTER_BUILD ? 200 : 100);
    check("center_ch0_high", 64'(hi_cnt[0]), CENTER_BUILD ? 64'd60 : 64'd30);
    check("center_ps_count", 64'(ps_cnt), 64'd1);
    check("center_next_start", 64'(period_start), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
